// File: rtl/fpu_seq_ctrl_pkg.sv
// Shared definitions for the CSR floating-point sequencer: op codes, FSM states,
// fctrl field layout and CSR indices.
package fpu_seq_ctrl_pkg;

    localparam logic [1:0] FOP_ADD = 2'd0;
    localparam logic [1:0] FOP_SUB = 2'd1;
    localparam logic [1:0] FOP_MUL = 2'd2;
    localparam logic [1:0] FOP_DIV = 2'd3;

    localparam logic [11:0] CSR_FCTRL = 12'h310;
    localparam logic [11:0] CSR_FACC  = 12'h311;
    localparam logic [11:0] CSR_FOP1  = 12'h312;
    localparam logic [11:0] CSR_FOP2  = 12'h313;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_S1   = 2'd1,
        ST_S2   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic       op1_dis;
        logic [1:0] op1;
        logic [1:0] op2;
    } fctrl_t;

endpackage

// File: rtl/fpu_seq_ctrl_res_sel.sv
// Result selector (module fpu_res_sel): picks the FPU32 output for one stage's op
// code and flags the unsupported divide, which yields a zero result.
module fpu_res_sel
    import fpu_seq_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_add,
    input  logic [XLEN-1:0] i_sub,
    input  logic [XLEN-1:0] i_mul,
    output logic [XLEN-1:0] o_res,
    output logic            o_unsup
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        o_res   = '0;
        o_unsup = 1'b0;
        case (i_op)
            FOP_ADD: o_res = i_add;
            FOP_SUB: o_res = i_sub;
            FOP_MUL: o_res = i_mul;
            default: o_unsup = 1'b1;
        endcase
    end

endmodule

// File: rtl/fpu_seq_ctrl.sv
// Two-stage accumulate sequencer facc = (facc op1 fop1) op2 fop2 on one shared FPU32.
// Optional completed-sequence counter o_opcnt when FPU_SEQ_OPCNT_EN is defined.
module fpu_seq_ctrl
    import fpu_seq_ctrl_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int FPU_LAT = 1
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_start,
    input  logic [4:0]      i_fctrl,
    input  logic [XLEN-1:0] i_fop1,
    input  logic [XLEN-1:0] i_fop2,
    input  logic            i_facc_wen,
    input  logic [XLEN-1:0] i_facc_wdata,
    output logic [XLEN-1:0] o_facc,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err,
    output logic [XLEN-1:0] o_fpu_op1,
    output logic [XLEN-1:0] o_fpu_op2,
    input  logic [XLEN-1:0] i_fpu_add,
    input  logic [XLEN-1:0] i_fpu_sub,
    input  logic [XLEN-1:0] i_fpu_mul
`ifdef FPU_SEQ_OPCNT_EN
    ,
    output logic [31:0]     o_opcnt
`endif
);

    localparam int CNT_W = (FPU_LAT > 0) ? $clog2(FPU_LAT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FPU_LAT);

    state_t          r_state;
    state_t          w_next;
    fctrl_t          r_fctrl;
    logic [XLEN-1:0] r_fop1;
    logic [XLEN-1:0] r_fop2;
    logic [XLEN-1:0] r_tmp;
    logic [XLEN-1:0] r_facc;
    logic [XLEN-1:0] r_op1_hold;
    logic [XLEN-1:0] r_op2_hold;
    logic [CNT_W-1:0] r_cnt;
    logic            r_err;
    logic            w_last;
    logic            w_idle;
    logic            w_launch;
    logic [XLEN-1:0] w_res1;
    logic [XLEN-1:0] w_res2;
    logic            w_unsup1;
    logic            w_unsup2;
    logic [XLEN-1:0] w_fpu_op1;
    logic [XLEN-1:0] w_fpu_op2;

    assign w_last   = (r_cnt == CNT_LAST);
    assign w_idle   = (r_state == ST_IDLE);
    assign w_launch = w_idle && i_start;

    fpu_res_sel #(.XLEN(XLEN)) u_sel1 (
        .i_op    (r_fctrl.op1),
        .i_add   (i_fpu_add),
        .i_sub   (i_fpu_sub),
        .i_mul   (i_fpu_mul),
        .o_res   (w_res1),
        .o_unsup (w_unsup1)
    );

    fpu_res_sel #(.XLEN(XLEN)) u_sel2 (
        .i_op    (r_fctrl.op2),
        .i_add   (i_fpu_add),
        .i_sub   (i_fpu_sub),
        .i_mul   (i_fpu_mul),
        .o_res   (w_res2),
        .o_unsup (w_unsup2)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_next = i_fctrl[4] ? ST_S2 : ST_S1;
            ST_S1:   if (w_last) w_next = ST_S2;
            ST_S2:   if (w_last) w_next = ST_DONE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Outside S1/S2 the FPU operands replay the last driven pair so they never toggle.
    always_comb begin
        o_busy    = 1'b0;
        o_done    = 1'b0;
        w_fpu_op1 = r_op1_hold;
        w_fpu_op2 = r_op2_hold;
        case (r_state)
            ST_S1: begin
                o_busy    = 1'b1;
                w_fpu_op1 = r_facc;
                w_fpu_op2 = r_fop1;
            end
            ST_S2: begin
                o_busy    = 1'b1;
                w_fpu_op1 = r_fctrl.op1_dis ? r_fop1 : r_tmp;
                w_fpu_op2 = r_fop2;
            end
            ST_DONE: o_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_fctrl    <= '0;
            r_fop1     <= '0;
            r_fop2     <= '0;
            r_tmp      <= '0;
            r_facc     <= '0;
            r_op1_hold <= '0;
            r_op2_hold <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
        end else begin
            r_op1_hold <= w_fpu_op1;
            r_op2_hold <= w_fpu_op2;

            if (w_launch) begin
                r_fctrl <= fctrl_t'(i_fctrl);
                r_fop1  <= i_fop1;
                r_fop2  <= i_fop2;
                r_err   <= 1'b0;
            end

            if (w_idle && i_facc_wen) r_facc <= i_facc_wdata;

            if (r_state == ST_S1 || r_state == ST_S2) begin
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end

            if (r_state == ST_S1 && w_last) begin
                r_tmp <= w_res1;
                if (w_unsup1) r_err <= 1'b1;
            end

            if (r_state == ST_S2 && w_last) begin
                r_facc <= w_res2;
                if (w_unsup2) r_err <= 1'b1;
            end
        end
    end

`ifdef FPU_SEQ_OPCNT_EN
    logic [31:0] r_opcnt;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)                  r_opcnt <= '0;
        else if (r_state == ST_DONE)  r_opcnt <= r_opcnt + 32'd1;
        else if (w_idle && i_facc_wen) r_opcnt <= '0;
    end

    assign o_opcnt = r_opcnt;
`endif

    assign o_facc    = r_facc;
    assign o_err     = r_err;
    assign o_fpu_op1 = w_fpu_op1;
    assign o_fpu_op2 = w_fpu_op2;

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// Directed bench for fpu_seq_ctrl with a behavioural one-cycle-latency FPU32 model.
module tb_fpu_seq_ctrl;

    typedef struct {
        string       name;
        logic [31:0] facc;
        logic [4:0]  fctrl;
        logic [31:0] fop1;
        logic [31:0] fop2;
        logic [31:0] exp_facc;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  fctrl = '0;
    logic [31:0] fop1 = '0;
    logic [31:0] fop2 = '0;
    logic        facc_wen = 1'b0;
    logic [31:0] facc_wdata = '0;
    logic [31:0] facc;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] fpu_op1;
    logic [31:0] fpu_op2;
    logic [31:0] fpu_add = '0;
    logic [31:0] fpu_sub = '0;
    logic [31:0] fpu_mul = '0;
`ifdef FPU_SEQ_OPCNT_EN
    logic [31:0] opcnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fpu_seq_ctrl #(.XLEN(32), .FPU_LAT(1)) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_start      (start),
        .i_fctrl      (fctrl),
        .i_fop1       (fop1),
        .i_fop2       (fop2),
        .i_facc_wen   (facc_wen),
        .i_facc_wdata (facc_wdata),
        .o_facc       (facc),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .o_fpu_op1    (fpu_op1),
        .o_fpu_op2    (fpu_op2),
        .i_fpu_add    (fpu_add),
        .i_fpu_sub    (fpu_sub),
        .i_fpu_mul    (fpu_mul)
`ifdef FPU_SEQ_OPCNT_EN
        ,
        .o_opcnt      (opcnt)
`endif
    );

    function automatic real sp2real(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:0] == 31'd0) return 0.0;
        d = {b[31], 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real2sp(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'd0;
        return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
    endfunction

    // FPU32 model: results appear one cycle after the operands are presented.
    always @(posedge clk) begin
        fpu_add <= real2sp(sp2real(fpu_op1) + sp2real(fpu_op2));
        fpu_sub <= real2sp(sp2real(fpu_op1) - sp2real(fpu_op2));
        fpu_mul <= real2sp(sp2real(fpu_op1) * sp2real(fpu_op2));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input vec_t v, input bit do_wr);
        int lat = 0;
        if (do_wr) begin
            @(negedge clk);
            facc_wen = 1'b1;
            facc_wdata = v.facc;
            tick();
            facc_wen = 1'b0;
            check({v.name, "_wr"}, facc, v.facc);
        end
        @(negedge clk);
        start = 1'b1;
        fctrl = v.fctrl;
        fop1 = v.fop1;
        fop2 = v.fop2;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 1) begin
                start = 1'b0;
                check({v.name, "_busy"}, 32'(busy), 32'd1);
                check({v.name, "_err_clr"}, 32'(err), 32'd0);
            end
            if (done) begin
                lat = n;
                break;
            end
        end
        check({v.name, "_lat"}, lat, v.exp_lat);
        check({v.name, "_facc"}, facc, v.exp_facc);
        check({v.name, "_busy_done"}, 32'(busy), 32'd0);
        tick();
        check({v.name, "_done_pulse"}, 32'(done), 32'd0);
        tick();
        check({v.name, "_err"}, 32'(err), 32'(v.exp_err));
    endtask

    vec_t vecs[6];
    int   ndone;

    initial begin
        vecs[0] = '{"mul_chain", 32'h3F800000, 5'b00010, 32'h40000000, 32'h40400000, 32'h41100000, 1'b0, 5};
        vecs[1] = '{"op1_off",   32'h3F800000, 5'b10000, 32'h40000000, 32'h40400000, 32'h40A00000, 1'b0, 3};
        vecs[2] = '{"div_op1",   32'h3F800000, 5'b01100, 32'h40000000, 32'h40400000, 32'h40400000, 1'b1, 5};
        vecs[3] = '{"sub_sub",   32'h40A00000, 5'b00101, 32'h40000000, 32'h40400000, 32'h00000000, 1'b0, 5};
        vecs[4] = '{"mul_add",   32'h40000000, 5'b01000, 32'h40400000, 32'h3F800000, 32'h40E00000, 1'b0, 5};
        vecs[5] = '{"div_op2",   32'h3F800000, 5'b10011, 32'h40000000, 32'h40400000, 32'h00000000, 1'b1, 3};

        #12;
        check("rst_facc", facc, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_op1", fpu_op1, 32'd0);
        check("rst_op2", fpu_op2, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 6; i++) run_seq(vecs[i], 1'b1);

        // After a sequence the FPU operands keep the last S2 pair: tmp=3.0, fop2=3.0.
        run_seq(vecs[0], 1'b1);
        tick();
        check("hold_op1", fpu_op1, 32'h40400000);
        check("hold_op2", fpu_op2, 32'h40400000);

        // Start and facc write during S1 must be ignored.
        @(negedge clk);
        facc_wen = 1'b1;
        facc_wdata = 32'h3F800000;
        @(negedge clk);
        facc_wen = 1'b0;
        start = 1'b1;
        fctrl = 5'b00010;
        fop1 = 32'h40000000;
        fop2 = 32'h40400000;
        ndone = 0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (n == 1) begin
                start = 1'b0;
                check("s1_op1", fpu_op1, 32'h3F800000);
                check("s1_op2", fpu_op2, 32'h40000000);
            end
            if (n == 2) begin
                start = 1'b1;
                fctrl = 5'b00101;
                fop1 = 32'h41200000;
                fop2 = 32'h41200000;
                facc_wen = 1'b1;
                facc_wdata = 32'h12345678;
            end
            if (n == 3) begin
                start = 1'b0;
                facc_wen = 1'b0;
            end
            if (done) ndone++;
        end
        check("busy_ign_done_cnt", ndone, 1);
        check("busy_ign_facc", facc, 32'h41100000);

        // Simultaneous write and start in IDLE: (2.0 + 1.0) + 1.0 = 4.0.
        @(negedge clk);
        facc_wen = 1'b1;
        facc_wdata = 32'h40000000;
        start = 1'b1;
        fctrl = 5'b00000;
        fop1 = 32'h3F800000;
        fop2 = 32'h3F800000;
        tick();
        facc_wen = 1'b0;
        start = 1'b0;
        ndone = 0;
        for (int n = 0; n < 10; n++) begin
            if (done) ndone++;
            tick();
        end
        check("wr_start_done_cnt", ndone, 1);
        check("wr_start_facc", facc, 32'h40800000);

        // Reset asserted during S2 aborts the sequence and clears facc.
        @(negedge clk);
        facc_wen = 1'b1;
        facc_wdata = 32'h3F800000;
        @(negedge clk);
        facc_wen = 1'b0;
        start = 1'b1;
        fctrl = 5'b00010;
        fop1 = 32'h40000000;
        fop2 = 32'h40400000;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        rstn = 1'b0;
        #1;
        check("mid_rst_facc", facc, 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        ndone = 0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (done) ndone++;
        end
        check("post_rst_no_done", ndone, 0);
        run_seq(vecs[0], 1'b1);

`ifdef FPU_SEQ_OPCNT_EN
        run_seq(vecs[4], 1'b1);
        run_seq(vecs[3], 1'b0);
        run_seq(vecs[1], 1'b0);
        check("opcnt_three", opcnt, 32'd3);
        @(negedge clk);
        facc_wen = 1'b1;
        facc_wdata = 32'h3F800000;
        tick();
        facc_wen = 1'b0;
        check("opcnt_clr", opcnt, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_seq_ctrl.md
Name: fpu_seq_ctrl

Overview:
- Sequencer for the custom CSR floating-point unit. Implements the two-stage accumulate `facc = (facc op1 fop1) op2 fop2` by time-sharing a single FPU32 instance across both stages.
- Sits between the CSR regfile's fctrl/fop1/fop2/facc registers and FPU32. It owns facc, latches the operands, and reports busy/done back to the pipeline.

Parameters:
- XLEN, 32, data width; must be 32 for FPU32.
- FPU_LAT, 1, FPU32 result latency in cycles after operands are presented (0 = combinational).

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_start  in  1  launch request (CSR write to fctrl)
- i_fctrl  in  5  [1:0] op2 code, [3:2] op1 code, [4] op1 disable
- i_fop1  in  XLEN  operand 1
- i_fop2  in  XLEN  operand 2
- i_facc_wen  in  1  direct CSR write of facc
- i_facc_wdata  in  XLEN  facc write data
- o_facc  out  XLEN  accumulator (CSR 0x311 read data)
- o_busy  out  1  sequence in flight
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  sticky: unsupported op code (div) encountered; cleared by i_start
- o_fpu_op1  out  XLEN  FPU32 operand 1
- o_fpu_op2  out  XLEN  FPU32 operand 2
- i_fpu_add  in  XLEN  FPU32 sum
- i_fpu_sub  in  XLEN  FPU32 difference
- i_fpu_mul  in  XLEN  FPU32 product

Behaviour:
- Clock and reset: single clock i_clk; reset i_rstn is asynchronous, active-low.
- Reset values: state=IDLE; o_facc, o_fpu_op1, o_fpu_op2 = 0; o_busy, o_done, o_err = 0. Reset mid-sequence aborts immediately and leaves facc=0.
- Op codes: 00 add, 01 sub, 10 mul, 11 div.
  - Div is unsupported: stage result = 0 and o_err is set.
- States: IDLE, S1, S2, DONE.
- IDLE:
  - i_start=1 latches fctrl/fop1/fop2 into shadow registers and clears o_err.
  - Next state is S1, or S2 if fctrl[4]=1.
  - o_busy=1 from the next cycle.
- S1:
  - Drives o_fpu_op1=facc, o_fpu_op2=shadow fop1.
  - A latency counter runs 0..FPU_LAT.
  - At count==FPU_LAT: capture the op1-selected result into tmp, reset the counter, go to S2.
  - Occupies FPU_LAT+1 cycles.
- S2:
  - Drives o_fpu_op1=tmp (or shadow fop1 if op1 is disabled), o_fpu_op2=shadow fop2.
  - At count==FPU_LAT: write the op2-selected result to facc, go to DONE.
  - Occupies FPU_LAT+1 cycles.
- DONE: o_done=1 for exactly one cycle, o_busy=0, then return to IDLE.
- Latency from the i_start edge to o_done high:
  - 2·(FPU_LAT+1)+1 cycles with op1 enabled (5 at FPU_LAT=1);
  - FPU_LAT+2 cycles with op1 disabled (3 at FPU_LAT=1).
- i_start while busy or in DONE: ignored. No queueing, shadow registers unchanged.
- i_facc_wen:
  - In IDLE: facc <= i_facc_wdata the next cycle.
  - While busy or in DONE: ignored.
  - Same cycle as i_start in IDLE: the write wins facc, and the sequence uses the written value.
- In IDLE the FPU operand outputs hold their last values (no toggling).
- o_facc is always the registered facc; it updates only in the last S2 cycle or on a write.

Optional Feature:
- Macro: FPU_SEQ_OPCNT_EN.
- Defined:
  - Adds output o_opcnt [31:0], a count of completed sequences.
  - Increments in the DONE cycle and wraps from 0xFFFFFFFF to 0.
  - Cleared by reset, or by i_facc_wen in IDLE.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/defines header:
  - op-code constants FOP_ADD=2'd0, FOP_SUB=2'd1, FOP_MUL=2'd2, FOP_DIV=2'd3;
  - state encodings;
  - CSR indices 0x310–0x313.
- Sub-module fpu_res_sel: a combinational mux from (op code, add/sub/mul) to result plus an unsupported flag, instantiated for both stages.
- The FSM and latency counter stay in the top module.

Test Plan:
- facc=0x3F800000 (1.0), fop1=0x40000000 (2.0), fop2=0x40400000 (3.0), fctrl=5'b00010 -> o_done 5 cycles after start; o_facc=0x41100000 (9.0); o_err=0.
- fctrl=5'b10000 (op1 off, add), fop1=2.0, fop2=3.0 -> o_done after 3 cycles; o_facc=0x40A00000 (5.0).
- fctrl op1=11 (div) -> o_err=1 sticky; tmp=0; final facc=0 op2 fop2; next i_start clears o_err.
- i_start and i_facc_wen pulsed during S1, with different fop values -> result matches the originally latched operands; facc not overwritten by the write; only one o_done.
- i_rstn low during S2 -> o_facc=0, o_busy=0, no o_done; a fresh sequence afterwards completes normally.
- FPU_SEQ_OPCNT_EN defined: three back-to-back sequences -> o_opcnt=3; facc write in IDLE -> o_opcnt=0.
